// File: rtl/optic_flow_pkg.sv
// Shared definitions for the optic-flow accumulator custom instruction.
// Optional pixel counter is enabled with OPTIC_FLOW_ACC_PIXEL_COUNT_EN.
package optic_flow_pkg;

  localparam int unsigned DEFAULT_COUNT_WIDTH = 16;
  localparam int unsigned NUM_DIRS            = 4;
  localparam int unsigned NUM_PIXELS          = 8;
  localparam int unsigned NIBBLE_W            = 4;

  // CI operation carried in valueB[1:0]
  typedef enum logic [1:0] {
    OP_ACCUM    = 2'd0,
    OP_READ     = 2'd1,
    OP_CLEAR    = 2'd2,
    OP_READ_NET = 2'd3
  } op_e;

  // READ counter select carried in valueA[2:0]
  localparam logic [2:0] SEL_RIGHT  = 3'd0;
  localparam logic [2:0] SEL_LEFT   = 3'd1;
  localparam logic [2:0] SEL_DOWN   = 3'd2;
  localparam logic [2:0] SEL_UP     = 3'd3;
  localparam logic [2:0] SEL_PIXELS = 3'd4;

  // Bit offset of each direction inside a pixel nibble; also the counter index
  localparam int unsigned BIT_RIGHT = 0;
  localparam int unsigned BIT_LEFT  = 1;
  localparam int unsigned BIT_DOWN  = 2;
  localparam int unsigned BIT_UP    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/optic_flow_accumulator_ci_popcount_8.sv
// Combinational population count of an 8-bit vector.
module popcount_8 (
  input  logic [7:0] i_bits,
  output logic [3:0] o_count
);

  // Sum of set bits, 0..8
  always_comb begin
    o_count = '0;
    for (int i = 0; i < 8; i++) begin
      o_count = o_count + 4'(i_bits[i]);
    end
  end

endmodule

// File: rtl/optic_flow_accumulator_ci.sv
// Per-frame accumulator of packed optic-flow words (custom instruction).
// Keeps saturating up/down/left/right counts and reports a clamped net vector.
// Define OPTIC_FLOW_ACC_PIXEL_COUNT_EN to add a count of pixels with any motion.
module optic_flow_accumulator_ci
  import optic_flow_pkg::*;
#(
  parameter logic [7:0]  customInstructionId = 8'd0,
  parameter int unsigned COUNT_WIDTH         = DEFAULT_COUNT_WIDTH
) (
  input  logic        clock,
  input  logic        nReset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned DW = COUNT_WIDTH + 1;
  localparam logic signed [DW-1:0] NET_MAX = DW'(32767);
  localparam logic signed [DW-1:0] NET_MIN = DW'(-32768);

  state_e                                r_state;
  op_e                                   r_op;
  logic [31:0]                           r_value;
  logic [NUM_DIRS-1:0][COUNT_WIDTH-1:0]  r_cnt;
  logic [NUM_DIRS-1:0][3:0]              r_pop;
  logic                                  r_done;
  logic [31:0]                           r_result;

  logic [NUM_DIRS-1:0][7:0]              w_dir_bits;
  logic [NUM_DIRS-1:0][3:0]              w_pop;
  logic [31:0]                           w_read_val;
  logic signed [DW-1:0]                  w_dx;
  logic signed [DW-1:0]                  w_dy;
  logic                                  w_unused;

  assign w_unused = ^valueB[31:2];

  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                     input logic [3:0] b);
    logic [DW-1:0] s;
    s = {1'b0, a} + DW'(b);
    if (s[COUNT_WIDTH]) return '1;
    return s[COUNT_WIDTH-1:0];
  endfunction

  function automatic logic [15:0] clamp16(input logic signed [DW-1:0] v);
    if (v > NET_MAX) return 16'h7FFF;
    if (v < NET_MIN) return 16'h8000;
    return v[15:0];
  endfunction

  // Regroup the latched flow word into one 8-bit vector per direction
  always_comb begin
    w_dir_bits = '0;
    for (int p = 0; p < NUM_PIXELS; p++) begin
      for (int d = 0; d < NUM_DIRS; d++) begin
        w_dir_bits[d][p] = r_value[NIBBLE_W*p + d];
      end
    end
  end

  for (genvar g = 0; g < NUM_DIRS; g++) begin : g_pop
    popcount_8 u_pop (
      .i_bits  (w_dir_bits[g]),
      .o_count (w_pop[g])
    );
  end

`ifdef OPTIC_FLOW_ACC_PIXEL_COUNT_EN
  logic [COUNT_WIDTH-1:0] r_pix;
  logic [3:0]             r_pix_pop;
  logic [7:0]             w_nz_bits;
  logic [3:0]             w_pix_pop;

  // One bit per pixel that reports motion in any direction
  always_comb begin
    w_nz_bits = '0;
    for (int p = 0; p < NUM_PIXELS; p++) begin
      w_nz_bits[p] = |r_value[NIBBLE_W*p +: NIBBLE_W];
    end
  end

  popcount_8 u_pop_pix (
    .i_bits  (w_nz_bits),
    .o_count (w_pix_pop)
  );
`endif

  // READ counter mux; unused selects return zero
  always_comb begin
    w_read_val = '0;
    if (r_value[2] == 1'b0) begin
      w_read_val = 32'(r_cnt[r_value[1:0]]);
    end
`ifdef OPTIC_FLOW_ACC_PIXEL_COUNT_EN
    else if (r_value[2:0] == SEL_PIXELS) begin
      w_read_val = 32'(r_pix);
    end
`endif
  end

  // Signed net motion, one bit wider than the counters
  always_comb begin
    w_dx = $signed({1'b0, r_cnt[BIT_RIGHT]}) - $signed({1'b0, r_cnt[BIT_LEFT]});
    w_dy = $signed({1'b0, r_cnt[BIT_DOWN]})  - $signed({1'b0, r_cnt[BIT_UP]});
  end

  // Control FSM, counters and registered outputs
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_ACCUM;
      r_value  <= '0;
      r_cnt    <= '0;
      r_pop    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
`ifdef OPTIC_FLOW_ACC_PIXEL_COUNT_EN
      r_pix     <= '0;
      r_pix_pop <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done   <= 1'b0;
          r_result <= '0;
          if (start && (ciN == customInstructionId)) begin
            r_op    <= op_e'(valueB[1:0]);
            r_value <= valueA;
            r_state <= (op_e'(valueB[1:0]) == OP_ACCUM) ? ST_POP : ST_EXEC;
          end
        end
        ST_POP: begin
          r_pop   <= w_pop;
`ifdef OPTIC_FLOW_ACC_PIXEL_COUNT_EN
          r_pix_pop <= w_pix_pop;
`endif
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_done   <= 1'b1;
          r_result <= '0;
          case (r_op)
            OP_ACCUM: begin
              for (int d = 0; d < NUM_DIRS; d++) begin
                r_cnt[d] <= sat_add(r_cnt[d], r_pop[d]);
              end
`ifdef OPTIC_FLOW_ACC_PIXEL_COUNT_EN
              r_pix <= sat_add(r_pix, r_pix_pop);
`endif
            end
            OP_READ:     r_result <= w_read_val;
            OP_CLEAR: begin
              r_cnt <= '0;
`ifdef OPTIC_FLOW_ACC_PIXEL_COUNT_EN
              r_pix <= '0;
`endif
            end
            OP_READ_NET: r_result <= {clamp16(w_dx), clamp16(w_dy)};
            default:     r_result <= '0;
          endcase
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done   <= 1'b0;
          r_result <= '0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule
